// File: rtl/fifo_double_line_buffer.sv
// Two-line circular delay buffer producing a vertical 3-pixel column; outputs registered, valid one edge after data_i is sampled.
// No backpressure: we_i low freezes every register, entry, pointer and counter, so stream gaps keep column alignment.
module fifo_double_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 5,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic                  done_o
);

  localparam int CNT_MAX   = 2 * LINE_WIDTH + 1;
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  logic [DATA_WIDTH-1:0] r_line1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] r_line2 [LINE_WIDTH];
  logic [PTR_WIDTH-1:0]  r_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [DATA_WIDTH-1:0] r_data2;
  logic                  r_done;

  logic                  w_ptr_last;
  logic                  w_cnt_sat;
  logic                  w_last_fill;
  logic [DATA_WIDTH-1:0] w_line1_rd;
  logic [DATA_WIDTH-1:0] w_line2_rd;

  assign w_ptr_last  = (r_ptr == PTR_WIDTH'(LINE_WIDTH - 1));
  assign w_cnt_sat   = (r_cnt == CNT_WIDTH'(CNT_MAX));
  // The write that brings the count from 2*LINE_WIDTH to its saturation value fills row n-2.
  assign w_last_fill = (r_cnt == CNT_WIDTH'(2 * LINE_WIDTH));
  assign w_line1_rd  = r_line1[r_ptr];
  assign w_line2_rd  = r_line2[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WIDTH; i++) begin
        r_line1[i] <= '0;
        r_line2[i] <= '0;
      end
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_done  <= 1'b0;
    end else if (we_i) begin
      r_data0        <= data_i;
      r_data1        <= w_line1_rd;
      r_data2        <= w_line2_rd;
      r_line1[r_ptr] <= data_i;
      r_line2[r_ptr] <= w_line1_rd;
      r_ptr          <= w_ptr_last ? '0 : r_ptr + 1'b1;
      if (!w_cnt_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last_fill) begin
        r_done <= 1'b1;
      end
    end
  end

  assign data0_o = r_data0;
  assign data1_o = r_data1;
  assign data2_o = r_data2;
  assign done_o  = r_done;

endmodule

// File: tb/tb_fifo_double_line_buffer.sv
// Bench for fifo_double_line_buffer: vector table, stall/wrap/reset sequences and a randomized run against a pixel-history model.
module tb_fifo_double_line_buffer;

  localparam int DW = 8;
  localparam int LW = 5;
  localparam int PW = 3;

  logic          clk;
  logic          rst;
  logic          we_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data0_o;
  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;
  logic          done_o;

  fifo_double_line_buffer #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW),
    .PTR_WIDTH (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .data_i (data_i),
    .data0_o(data0_o),
    .data1_o(data1_o),
    .data2_o(data2_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int hist[$];

  typedef struct {
    int we;
    int d;
    int e0;
    int e1;
    int e2;
    int ed;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_outs(input string tag, input int e0, input int e1, input int e2, input int ed);
    check({tag, ".data0"}, int'(data0_o), e0);
    check({tag, ".data1"}, int'(data1_o), e1);
    check({tag, ".data2"}, int'(data2_o), e2);
    check({tag, ".done"},  int'(done_o),  ed);
  endtask

  // Expected column straight from the accepted-pixel history.
  task automatic check_model(input string tag);
    int k;
    int e0;
    int e1;
    int e2;
    int ed;
    k  = hist.size() - 1;
    e0 = (k >= 0)      ? hist[k]        : 0;
    e1 = (k >= LW)     ? hist[k - LW]   : 0;
    e2 = (k >= 2 * LW) ? hist[k - 2*LW] : 0;
    ed = (hist.size() >= 2 * LW + 1) ? 1 : 0;
    check_outs(tag, e0, e1, e2, ed);
  endtask

  task automatic drive(input bit we, input int d);
    we_i   = we;
    data_i = DW'(d);
    @(posedge clk);
    #1;
    if (we) hist.push_back(d & 255);
  endtask

  task automatic quick_reset();
    we_i = 1'b0;
    rst  = 1'b1;
    hist.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    we_i   = 1'b0;
    data_i = '0;

    // Ramp 0..14 then three idle cycles.
    for (int i = 0; i < 15; i++) vecs[i] = '{1, i, i, (i >= 5) ? i - 5 : 0, (i >= 10) ? i - 10 : 0, (i >= 10) ? 1 : 0};
    vecs[2]  = '{1, 2, 2, 0, 0, 0};
    vecs[4]  = '{1, 4, 4, 0, 0, 0};
    vecs[7]  = '{1, 7, 7, 2, 0, 0};
    vecs[10] = '{1, 10, 10, 5, 0, 1};
    vecs[14] = '{1, 14, 14, 9, 4, 1};
    vecs[15] = '{0, 99, 14, 9, 4, 1};
    vecs[16] = '{0, 77, 14, 9, 4, 1};
    vecs[17] = '{0, 55, 14, 9, 4, 1};

    // Reset asserted while writes are offered.
    #2;
    rst    = 1'b1;
    we_i   = 1'b1;
    data_i = DW'($urandom);
    #1;
    check_outs("rst_async", 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      data_i = DW'($urandom);
    end
    #1;
    check_outs("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst  = 1'b0;
    we_i = 1'b0;
    #1;
    check_outs("rst_release", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rst_idle_edge", 0, 0, 0, 0);
    hist.delete();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we != 0, vecs[i].d);
      check_outs($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].ed);
    end

    // Every third cycle idle; final column must match the ramp.
    quick_reset();
    begin
      int px;
      int cyc;
      px  = 0;
      cyc = 0;
      while (px < 15 && cyc < 100) begin
        if (cyc % 3 == 2) begin
          drive(1'b0, int'($urandom_range(255)));
        end else begin
          drive(1'b1, px);
          px++;
        end
        check_model($sformatf("stall_c%0d", cyc));
        check($sformatf("stall_done_c%0d", cyc), int'(done_o), (px >= 11) ? 1 : 0);
        cyc++;
      end
      check("stall_pixels", px, 15);
    end
    check_outs("stall_final", 14, 9, 4, 1);

    // Long stream across many pointer wraps.
    quick_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, k);
      if (k >= 10) begin
        check($sformatf("wrap_d1_k%0d", k), int'(data1_o), k - 5);
        check($sformatf("wrap_d2_k%0d", k), int'(data2_o), k - 10);
      end
    end
    check_model("wrap_end");

    // Asynchronous reset mid-stream, then refill.
    quick_reset();
    for (int k = 0; k <= 12; k++) drive(1'b1, k);
    we_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outs("midrst", 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    hist.delete();
    for (int k = 0; k <= 10; k++) begin
      drive(1'b1, k);
      if (k == 9) check("refill_done_k9", int'(done_o), 0);
    end
    check_outs("refill", 10, 5, 0, 1);

    // Randomized traffic with gaps.
    quick_reset();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(3) != 0, int'($urandom_range(255)));
      check_model($sformatf("rand_c%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_double_line_buffer.md
Name: fifo_double_line_buffer

Overview:
- Streaming two-line delay buffer for the Sobel filter front end.
- Accepts one 8-bit pixel per write-enabled clock in raster order.
- Presents a vertical 3-pixel column: the current pixel, the pixel one line above and the pixel two lines above.
- Feeds the 3x3 window/convolution stage; done_o flags that the two-line history is filled and the column is valid.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 5, pixels per image line; also the depth of each line buffer.
- PTR_WIDTH, 3, address width; must satisfy 2^PTR_WIDTH >= LINE_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- we_i  input  1  write enable; one pixel accepted per rising edge while high.
- data_i  input  DATA_WIDTH  incoming pixel.
- data0_o  output  DATA_WIDTH  most recently accepted pixel (row n).
- data1_o  output  DATA_WIDTH  pixel accepted LINE_WIDTH writes earlier (row n-1).
- data2_o  output  DATA_WIDTH  pixel accepted 2*LINE_WIDTH writes earlier (row n-2).
- done_o  output  1  high once data2_o holds a real pixel.

Behaviour:
- Reset (rst=1, asynchronous):
  - data0_o, data1_o, data2_o and done_o = 0.
  - Write pointer = 0; write counter = 0.
  - All line-buffer entries = 0.
  - Reset mid-stream discards all history; the stream restarts from pixel 0.
- Storage: two arrays, line1 and line2, each LINE_WIDTH x DATA_WIDTH, sharing one write pointer ptr.
- On a rising edge with we_i=1, all updates happen simultaneously, using pre-edge values:
  - data0_o <= data_i
  - data1_o <= line1[ptr]
  - data2_o <= line2[ptr]
  - line1[ptr] <= data_i
  - line2[ptr] <= line1[ptr] (old value)
  - ptr <= (ptr == LINE_WIDTH-1) ? 0 : ptr+1
- Latency: outputs are registered and reflect the write on the same edge, i.e. valid one edge after data_i is sampled.
- After the k-th accepted pixel (k from 0):
  - data0_o = p[k]
  - data1_o = p[k-LINE_WIDTH], or 0 if k < LINE_WIDTH
  - data2_o = p[k-2*LINE_WIDTH], or 0 if k < 2*LINE_WIDTH
- we_i=0: every register, array entry, pointer and counter holds its value. Gaps in the stream are allowed; stalls do not corrupt alignment.
- Write counter:
  - Increments on each accepted write.
  - Saturates at 2*LINE_WIDTH+1; no wrap.
- done_o:
  - Registered; goes 1 on the edge that accepts pixel index 2*LINE_WIDTH (the (2*LINE_WIDTH+1)-th write).
  - Sticky high until rst.
  - Not affected by we_i dropping.
- Pointer wrap: after index LINE_WIDTH-1 the next write uses address 0. There is no full/empty condition; the buffer is a continuous circular delay line.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst with random data_i and we_i=1 → all outputs 0, done_o=0. Release at a negedge → no change until the first write edge.
- Fill ramp, LINE_WIDTH=5: write data_i=0..14 on consecutive cycles.
  - After write of 4: data0=4, data1=0, data2=0, done=0.
  - After write of 7: data0=7, data1=2, data2=0, done=0.
  - After write of 10: data0=10, data1=5, data2=0, done=1.
  - After write of 14: data0=14, data1=9, data2=4, done=1.
- Hold: after the 15 writes, drop we_i for 3 cycles → outputs stay 14/9/4, done_o stays 1.
- Stall alignment: write 0..14 with we_i deasserted every third cycle → the same final values (14/9/4) and done_o rising on the 11th accepted write.
- Wrap / long stream: write 0..39 continuously → after each write k≥10: data1_o = k-5, data2_o = k-10, confirming pointer wrap across 8 line periods.
- Mid-stream reset: pulse rst asynchronously (between edges) after write 12 → outputs immediately 0 and done_o=0. Re-write 0..10 → done_o rises again on the 11th write, with data2_o=0 (pixel 0), data1_o=5, data0_o=10.
